// File: rtl/fifo_reader_if.sv
// fifo_reader_if
//   Bundles the FIFO read port and the downstream delivery port of fifo_reader.
//   master : the reader (drives pop, data_o, valid_o)
//   slave  : the FIFO/downstream side (drives fifo_empty, data_out, valid_out,
//            fifo_error, dest_pause)
//   Signals:
//     pop         reader -> FIFO   pop request
//     fifo_empty  FIFO -> reader   FIFO empty flag
//     data_out    FIFO -> reader   read data, valid with valid_out
//     valid_out   FIFO -> reader   read data valid (cycle after pop)
//     fifo_error  FIFO -> reader   FIFO error flag
//     dest_pause  consumer -> reader  stall request
//     data_o      reader -> consumer  delivered word
//     valid_o     reader -> consumer  delivered word valid
interface fifo_reader_if #(
    parameter int DW = 8
);
    logic          pop;
    logic          fifo_empty;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          fifo_error;
    logic          dest_pause;
    logic [DW-1:0] data_o;
    logic          valid_o;

    modport master (
        output pop, data_o, valid_o,
        input  fifo_empty, data_out, valid_out, fifo_error, dest_pause
    );

    modport slave (
        input  pop, data_o, valid_o,
        output fifo_empty, data_out, valid_out, fifo_error, dest_pause
    );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader
//   Read-side controller for the team FIFO. Issues pops, captures returned words
//   into a 2-entry skid buffer and forwards them to a downstream consumer that can
//   stall with dest_pause.
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous active-high reset
//     enable     1 = may pop; 0 = stop popping, finish in-flight words
//     clear_err  pulse, leaves the error state
//     bus        fifo_reader_if.master (FIFO read port + downstream port)
//     rd_count   words delivered on valid_o, wraps modulo 2^CW
//     err        1 while in the error state
//     busy       1 while a pop is in flight or the skid holds data
module fifo_reader #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           clear_err,
    fifo_reader_if.master  bus,
    output logic [CW-1:0]  rd_count,
    output logic           err,
    output logic           busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          inflight;
    logic [1:0]    occ;
    logic [DW-1:0] sk0;     // head
    logic [DW-1:0] sk1;     // tail when occ == 2
    logic          cap;
    logic          drain;
    logic          err_ev;
    logic          room;

    always_comb begin
        // Only requested words are captured; unrequested ones are dropped.
        cap    = bus.valid_out && inflight;
        // A word arriving into an empty skid is forwarded straight to the
        // output register, giving 2-cycle pop->valid_o latency and allowing a
        // pop every cycle while the consumer keeps up.
        drain  = !bus.dest_pause && ((occ != 2'd0) || cap);
        err_ev = bus.fifo_error
              || (bus.valid_out && !inflight)
              || (inflight && !bus.valid_out);
        // Counting the in-flight word keeps the skid from overflowing even if
        // dest_pause rises while the response is on its way.
        room   = ({1'b0, occ} + {2'b00, inflight}) < 3'd2;
    end

    always_comb begin
        state_nx = state;
        bus.pop  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nx = RUN;
            end
            RUN: begin
                bus.pop = !bus.fifo_empty && room;
                if (err_ev)       state_nx = ERR;
                else if (!enable) state_nx = DRAIN;
            end
            DRAIN: begin
                if (err_ev)                          state_nx = ERR;
                else if (enable)                     state_nx = RUN;
                else if (!inflight && occ == 2'd0)   state_nx = IDLE;
            end
            ERR: begin
                if (clear_err) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight    <= 1'b0;
            occ         <= 2'd0;
            sk0         <= '0;
            sk1         <= '0;
            bus.data_o  <= '0;
            bus.valid_o <= 1'b0;
            rd_count    <= '0;
        end else begin
            // A response (or its absence) always retires the previous pop.
            inflight    <= bus.pop;
            bus.valid_o <= drain;
            if (drain) begin
                bus.data_o <= (occ == 2'd0) ? bus.data_out : sk0;
                rd_count   <= rd_count + CW'(1);
            end
            case ({cap, drain})
                2'b11: begin
                    if (occ == 2'd1) begin
                        sk0 <= bus.data_out;
                    end else if (occ == 2'd2) begin
                        sk0 <= sk1;
                        sk1 <= bus.data_out;
                    end
                end
                2'b01: begin
                    sk0 <= sk1;
                    occ <= occ - 2'd1;
                end
                2'b10: begin
                    if (occ == 2'd0) sk0 <= bus.data_out;
                    else             sk1 <= bus.data_out;
                    occ <= occ + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign err  = (state == ERR);
    assign busy = inflight || (occ != 2'd0);
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader
//   Directed bench for fifo_reader with a behavioural FIFO (pop in cycle N ->
//   data_out/valid_out in cycle N+1) and an in-order scoreboard on valid_o.
module tb_fifo_reader;
    logic       clk;
    logic       reset;
    logic       enable;
    logic       clear_err;
    logic [7:0] rd_count;
    logic       err;
    logic       busy;

    fifo_reader_if #(.DW(8)) bus ();

    fifo_reader #(.DW(8), .CW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .clear_err (clear_err),
        .bus       (bus),
        .rd_count  (rd_count),
        .err       (err),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         checks;
    int         failures;
    int         cyc;
    int         delivered;
    int         pops;
    int         first_pop, last_pop, first_out, last_out;
    int         ferr_seen;
    logic       pend, pend_err, inject;
    logic [7:0] q[$];
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard just after the edge, FIFO model at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.valid_o) begin
            delivered++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            if (exp_q.size() == 0) check("extra_word", {31'd0, bus.valid_o}, 32'd0);
            else                   check("data", {24'd0, bus.data_o}, {24'd0, exp_q.pop_front()});
        end
        @(negedge clk);
        if (pend) begin
            bus.data_out  = q.pop_front();
            bus.valid_out = 1'b1;
        end else begin
            bus.valid_out = inject;
            if (inject) bus.data_out = 8'hEE;
        end
        inject         = 1'b0;
        bus.fifo_error = pend_err;
        if (pend_err) ferr_seen++;
        pend           = 1'b0;
        pend_err       = 1'b0;
        bus.fifo_empty = (q.size() == 0);
        #1;
        if (bus.pop) begin
            pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            if (q.size() == 0) pend_err = 1'b1;
            else               pend     = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        enable         = 1'b0;
        clear_err      = 1'b0;
        bus.dest_pause = 1'b0;
        bus.valid_out  = 1'b0;
        bus.data_out   = '0;
        bus.fifo_error = 1'b0;
        bus.fifo_empty = 1'b1;
        q.delete();
        exp_q.delete();
        pend = 1'b0; pend_err = 1'b0; inject = 1'b0;
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        delivered = 0; pops = 0; ferr_seen = 0;
        first_pop = -1; last_pop = -1; first_out = -1; last_out = -1;
    endtask

    task automatic load(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            q.push_back(base + 8'(i));
            exp_q.push_back(base + 8'(i));
        end
        bus.fifo_empty = (q.size() == 0);
    endtask

    task automatic run_until(input int target, input int budget);
        for (int g = 0; g < budget && delivered < target; g++) tick();
    endtask

    int p0, d0;

    initial begin
        checks = 0; failures = 0; cyc = 0;
        reset = 1'b1;
        #1;
        check("rst_valid_o",  {31'd0, bus.valid_o}, 32'd0);
        check("rst_data_o",   {24'd0, bus.data_o},  32'd0);
        check("rst_rd_count", {24'd0, rd_count},    32'd0);
        check("rst_err",      {31'd0, err},         32'd0);
        check("rst_busy",     {31'd0, busy},        32'd0);
        check("rst_pop",      {31'd0, bus.pop},     32'd0);

        // 1) three words, unpaused
        do_reset();
        load(3, 8'hE1);
        enable = 1'b1;
        run_until(3, 20);
        repeat (3) tick();
        check("t1_delivered", delivered, 3);
        check("t1_pops", pops, 3);
        check("t1_pop_run", last_pop - first_pop, 2);
        check("t1_latency", first_out - first_pop, 2);
        check("t1_out_run", last_out - first_out, 2);
        check("t1_rd_count", {24'd0, rd_count}, 32'd3);
        check("t1_pop_after", {31'd0, bus.pop}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd0);

        // 2) pause after the first delivery
        do_reset();
        load(4, 8'hA1);
        enable = 1'b1;
        run_until(1, 20);
        bus.dest_pause = 1'b1;
        d0 = delivered;
        repeat (5) tick();
        check("t2_paused_out", delivered, d0);
        check("t2_pop_sat", {31'd0, bus.pop}, 32'd0);
        check("t2_busy", {31'd0, busy}, 32'd1);
        check("t2_fifo_left", q.size(), 1);
        bus.dest_pause = 1'b0;
        run_until(4, 20);
        repeat (3) tick();
        check("t2_delivered", delivered, 4);
        check("t2_rd_count", {24'd0, rd_count}, 32'd4);
        check("t2_exp_left", exp_q.size(), 0);

        // 3) empty FIFO
        do_reset();
        enable = 1'b1;
        repeat (8) tick();
        check("t3_pops", pops, 0);
        check("t3_fifo_error", ferr_seen, 0);
        check("t3_err", {31'd0, err}, 32'd0);
        check("t3_busy", {31'd0, busy}, 32'd0);

        // 4) unrequested valid_out
        do_reset();
        enable = 1'b1;
        repeat (2) tick();
        inject = 1'b1;
        tick();
        tick();
        check("t4_err", {31'd0, err}, 32'd1);
        check("t4_pop", {31'd0, bus.pop}, 32'd0);
        check("t4_dropped", {31'd0, bus.valid_o}, 32'd0);
        tick();
        check("t4_err_hold", {31'd0, err}, 32'd1);
        enable    = 1'b0;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("t4_err_clr", {31'd0, err}, 32'd0);
        load(2, 8'h51);
        enable = 1'b1;
        run_until(2, 20);
        repeat (2) tick();
        check("t4_resume", delivered, 2);
        check("t4_rd_count", {24'd0, rd_count}, 32'd2);

        // 5) enable dropped mid-burst, then reset mid-burst
        do_reset();
        load(6, 8'hB1);
        enable = 1'b1;
        run_until(1, 20);
        enable = 1'b0;
        repeat (6) tick();
        check("t5_drain_max", {31'd0, (delivered <= 3)}, 32'd1);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_pop", {31'd0, bus.pop}, 32'd0);
        check("t5_rd_count", {24'd0, rd_count}, 32'(delivered));
        d0 = delivered;
        enable = 1'b1;
        run_until(d0 + 1, 20);
        check("t5_pre_rst_valid", {31'd0, bus.valid_o}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("t5_rst_valid_o",  {31'd0, bus.valid_o}, 32'd0);
        check("t5_rst_data_o",   {24'd0, bus.data_o},  32'd0);
        check("t5_rst_rd_count", {24'd0, rd_count},    32'd0);
        check("t5_rst_busy",     {31'd0, busy},        32'd0);
        check("t5_rst_pop",      {31'd0, bus.pop},     32'd0);

        // 6) rd_count wrap
        do_reset();
        load(257, 8'h00);
        enable = 1'b1;
        run_until(256, 700);
        check("t6_256", delivered, 256);
        check("t6_wrap0", {24'd0, rd_count}, 32'd0);
        run_until(257, 20);
        check("t6_257", delivered, 257);
        check("t6_wrap1", {24'd0, rd_count}, 32'd1);
        p0 = pops;
        repeat (3) tick();
        check("t6_no_more_pops", pops, p0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
